// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing one DFFRAM512x32 port, with round-robin or fixed tie-break and burst locks.
// Latency: grant and RAM drive are combinational (0 cycles); read data returns one cycle after the grant.
// Backpressure: a requester holds req/we/a/di until granted; a held lock blocks the other requester. Macro RAM_ARB_RR_EN.
module ram_port_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic            lock0,
    input  logic            lock1,
    input  logic [DW/8-1:0] we0,
    input  logic [DW/8-1:0] we1,
    input  logic [AW-1:0]   a0,
    input  logic [AW-1:0]   a1,
    input  logic [DW-1:0]   di0,
    input  logic [DW-1:0]   di1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DW-1:0]   rdata0,
    output logic [DW-1:0]   rdata1,
    output logic            ram_en,
    output logic [DW/8-1:0] ram_we,
    output logic [AW-1:0]   ram_a,
    output logic [DW-1:0]   ram_di,
    input  logic [DW-1:0]   ram_do,
    output logic            busy
);

    localparam int BW = DW / 8;

    logic own_q;
    logic locked_q;
    logic rpend_q;
    logic rtag_q;
`ifdef RAM_ARB_RR_EN
    logic last_q;
`endif

    logic xfer;
    logic win;
    logic lock_win;
    logic lock_own;

    // Grant selection: an active lock overrides everything, then a lone requester, then the tie-break.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (locked_q) begin
            if (own_q) gnt1 = req1;
            else       gnt0 = req0;
        end else if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
`else
            gnt0 = 1'b1;
`endif
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign xfer     = gnt0 | gnt1;
    assign win      = gnt1;
    assign lock_win = win ? lock1 : lock0;
    assign lock_own = own_q ? lock1 : lock0;

    // Steer the winner onto the RAM port; an idle port is driven to all zeros.
    always_comb begin
        ram_en = xfer;
        ram_we = '0;
        ram_a  = '0;
        ram_di = '0;
        if (gnt1) begin
            ram_we = we1;
            ram_a  = a1;
            ram_di = di1;
        end else if (gnt0) begin
            ram_we = we0;
            ram_a  = a0;
            ram_di = di0;
        end
    end

    // Lock ownership and the one-deep read-return tag; reset drops both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_q    <= 1'b0;
            locked_q <= 1'b0;
            rpend_q  <= 1'b0;
            rtag_q   <= 1'b0;
        end else begin
            if (xfer) begin
                // While locked only the owner can transfer, so this also covers lock renewal/release.
                locked_q <= lock_win;
                if (lock_win) own_q <= win;
            end else if (locked_q && !lock_own) begin
                locked_q <= 1'b0;
            end
            rpend_q <= xfer && (ram_we == BW'(0));
            rtag_q  <= win;
        end
    end

`ifdef RAM_ARB_RR_EN
    // Remember the last winner so the other side takes the next tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (xfer) begin
            last_q <= win;
        end
    end
`endif

    assign rvalid0 = rpend_q & ~rtag_q;
    assign rvalid1 = rpend_q & rtag_q;
    assign rdata0  = ram_do;
    assign rdata1  = ram_do;
    assign busy    = xfer | rpend_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural DFFRAM model.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Tie-break expectations follow RAM_ARB_RR_EN when it is defined.
module tb_ram_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, lock0, lock1;
    logic [BW-1:0] we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] di0, di1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_en;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [512];

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .a0(a0), .a1(a1), .di0(di0), .di1(di1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
        .ram_do(ram_do), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: contents preset while reset is low, registered read data, byte-masked writes.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
            mem[5] <= 32'hDEADBEEF;
            ram_do <= '0;
        end else if (ram_en) begin
            if (ram_we == '0) begin
                ram_do <= mem[ram_a];
            end else begin
                for (int b = 0; b < BW; b++)
                    if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic exp_w [6];

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        we0 = '0; we1 = '0; a0 = '0; a1 = '0; di0 = '0; di1 = '0;
        tick();
        tick();
        #1;
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_rvalid0", 32'(rvalid0), 0);
        check("rst_rvalid1", 32'(rvalid1), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ram_en", 32'(ram_en), 0);

        // Single read, same-cycle grant, data the next cycle.
        rst_n = 1'b1;
        req0 = 1; a0 = 9'h005; we0 = '0;
        #1;
        check("rd_gnt0", 32'(gnt0), 1);
        check("rd_gnt1", 32'(gnt1), 0);
        check("rd_ram_en", 32'(ram_en), 1);
        check("rd_ram_a", 32'(ram_a), 32'h005);
        check("rd_busy", 32'(busy), 1);
        tick();
        req0 = 0;
        #1;
        check("rd_rvalid0", 32'(rvalid0), 1);
        check("rd_rdata0", rdata0, 32'hDEADBEEF);
        check("rd_rvalid1", 32'(rvalid1), 0);
        check("rd_busy_ret", 32'(busy), 1);
        tick();
        #1;
        check("rd_rvalid0_off", 32'(rvalid0), 0);
        check("idle_busy", 32'(busy), 0);

        // Both requesters held for six cycles after a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef RAM_ARB_RR_EN
        exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 6; k++) begin
            req0 = 1; req1 = 1;
            a0 = 9'(k); a1 = 9'(k + 8);
            #1;
            check($sformatf("tie%0d_gnt0", k), 32'(gnt0), 32'(!exp_w[k]));
            check($sformatf("tie%0d_gnt1", k), 32'(gnt1), 32'(exp_w[k]));
            if (k > 0) check($sformatf("tie%0d_rvalid1", k), 32'(rvalid1), 32'(exp_w[k-1]));
            tick();
        end
        req0 = 0; req1 = 0;

        // Partial write by requester 1, read back by requester 0.
        req1 = 1; a1 = 9'h1FF; di1 = 32'h12345678; we1 = 4'b0011;
        #1;
        check("wr_gnt1", 32'(gnt1), 1);
        check("wr_ram_we", 32'(ram_we), 32'h3);
        check("wr_ram_a", 32'(ram_a), 32'h1FF);
        check("wr_ram_di", ram_di, 32'h12345678);
        tick();
        req1 = 0; we1 = '0;
        req0 = 1; a0 = 9'h1FF; we0 = '0;
        #1;
        check("wr_no_rvalid1", 32'(rvalid1), 0);
        check("rb_gnt0", 32'(gnt0), 1);
        tick();
        req0 = 0;
        #1;
        check("rb_rvalid0", 32'(rvalid0), 1);
        check("rb_rdata0", rdata0, 32'h00005678);

        // Lock held by requester 0 across three accesses and a two-cycle idle.
        req0 = 1; lock0 = 1; a0 = 9'h005;
        #1;
        check("lk0_gnt0", 32'(gnt0), 1);
        check("lk0_gnt1", 32'(gnt1), 0);
        tick();
        req1 = 1; a1 = 9'h005; we1 = '0;
        for (int i = 1; i < 3; i++) begin
            #1;
            check($sformatf("lk%0d_gnt0", i), 32'(gnt0), 1);
            check($sformatf("lk%0d_gnt1", i), 32'(gnt1), 0);
            tick();
        end
        req0 = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("lk_idle%0d_gnt1", i), 32'(gnt1), 0);
            tick();
        end
        lock0 = 0;
        #1;
        check("lk_fall_gnt1", 32'(gnt1), 0);
        tick();
        #1;
        check("lk_after_gnt1", 32'(gnt1), 1);
        tick();
        req1 = 0;
        #1;
        check("lk_rvalid1", 32'(rvalid1), 1);
        check("lk_rdata1", rdata1, 32'hDEADBEEF);
        tick();

        // Reset releases a lock and drops a pending read return.
        req0 = 1; lock0 = 1;
        #1;
        check("rl_gnt0", 32'(gnt0), 1);
        tick();
        req0 = 0; rst_n = 1'b0;
        tick();
        req1 = 1; a1 = 9'h005;
        #1;
        check("rl_gnt1", 32'(gnt1), 1);
        tick();
        req1 = 0; rst_n = 1'b1;
        #1;
        check("rl_rvalid1", 32'(rvalid1), 0);
        check("rl_busy", 32'(busy), 0);
        check("rl_ram_en", 32'(ram_en), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
